// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: data widths, ALU func codes,
// the BTB entry layout and branch-class helpers.
package branch_predictor_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned FUNC_W = 5;

    typedef logic [FUNC_W-1:0] alu_func_t;

    localparam alu_func_t BR_BEQ  = 5'h0e;
    localparam alu_func_t BR_BNE  = 5'h0f;
    localparam alu_func_t BR_BLT  = 5'h10;
    localparam alu_func_t BR_BGE  = 5'h11;
    localparam alu_func_t BR_BLTU = 5'h12;
    localparam alu_func_t BR_BGEU = 5'h13;
    localparam alu_func_t BR_JAL  = 5'h14;
    localparam alu_func_t BR_JALR = 5'h15;

    // Tag is kept full width so the entry layout does not depend on table depth.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        logic [1:0]      ctr;
        logic            uncond;
    } btb_entry_t;

    function automatic logic is_branch_func(input alu_func_t f);
        return (f >= BR_BEQ) && (f <= BR_JALR);
    endfunction

    function automatic logic is_uncond_func(input alu_func_t f);
        return (f == BR_JAL) || (f == BR_JALR);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and branch-resolution update signals of the branch predictor.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    alu_func_t       upd_func;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;

    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output if_valid, if_pc, upd_valid, upd_pc, upd_func, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_valid, if_pc, upd_valid, upd_pc, upd_func, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic of a 2-bit saturating counter with increment, decrement and load.
module sat_counter2 (
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       set_i,
    input  logic [1:0] set_val_i,
    output logic [1:0] ctr_o
);
    always_comb begin
        ctr_o = ctr_i;
        if (set_i) begin
            ctr_o = set_val_i;
        end else if (inc_i && (ctr_i != 2'd3)) begin
            ctr_o = ctr_i + 2'd1;
        end else if (dec_i && (ctr_i != 2'd0)) begin
            ctr_o = ctr_i - 2'd1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup for fetch,
// training from resolved branches and a registered mispredict/redirect.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16
) (
    input logic               clock,
    input logic               reset_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned SH    = IDX_W + 2;

    btb_entry_t btb_q [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    btb_entry_t       lk_e;
    logic             lk_hit;
    logic             lk_taken;

    // Lookup reads the registered table only, so a same-cycle update is not visible.
    always_comb begin
        lk_idx   = IDX_W'(bp.if_pc >> 2);
        lk_e     = btb_q[lk_idx];
        lk_hit   = bp.if_valid && lk_e.valid && (lk_e.tag == XLEN'(bp.if_pc >> SH));
        lk_taken = lk_hit && (lk_e.uncond || lk_e.ctr[1]);
    end

    assign bp.pred_hit    = lk_hit;
    assign bp.pred_taken  = lk_taken;
    assign bp.pred_target = lk_taken    ? lk_e.target :
                            bp.if_valid ? bp.if_pc + XLEN'(4) : '0;

    logic [IDX_W-1:0] up_idx;
    btb_entry_t       up_old;
    btb_entry_t       up_new;
    logic             up_br;
    logic             up_unc;
    logic             up_hit;
    logic             up_we;
    logic [1:0]       up_ctr;
    logic             ctr_inc;
    logic             ctr_dec;
    logic             ctr_set;
    logic [1:0]       ctr_set_val;

    always_comb begin
        up_idx      = IDX_W'(bp.upd_pc >> 2);
        up_old      = btb_q[up_idx];
        up_br       = is_branch_func(bp.upd_func);
        up_unc      = is_uncond_func(bp.upd_func);
        up_hit      = up_old.valid && (up_old.tag == XLEN'(bp.upd_pc >> SH));
        up_we       = bp.upd_valid && up_br && (up_hit || bp.upd_taken);
        ctr_inc     = up_hit && !up_unc && bp.upd_taken;
        ctr_dec     = up_hit && !up_unc && !bp.upd_taken;
        ctr_set     = !up_hit || up_unc;
        ctr_set_val = up_unc ? 2'd3 : 2'd2;

        up_new        = up_old;
        up_new.valid  = 1'b1;
        up_new.tag    = XLEN'(bp.upd_pc >> SH);
        up_new.ctr    = up_ctr;
        up_new.uncond = up_hit ? (up_old.uncond || up_unc) : up_unc;
        if (bp.upd_taken || up_unc) begin
            up_new.target = bp.upd_target;
        end
    end

    sat_counter2 u_ctr (
        .ctr_i     (up_old.ctr),
        .inc_i     (ctr_inc),
        .dec_i     (ctr_dec),
        .set_i     (ctr_set),
        .set_val_i (ctr_set_val),
        .ctr_o     (up_ctr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_q[i] <= '0;
            end
        end else if (up_we) begin
            btb_q[up_idx] <= up_new;
        end
    end

    logic            mispredict_d, mispredict_q;
    logic [XLEN-1:0] redirect_d, redirect_q;

    always_comb begin
        mispredict_d = bp.upd_valid && up_br &&
                       ((bp.upd_taken != bp.upd_pred_taken) ||
                        (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
        redirect_d   = redirect_q;
        if (mispredict_d) begin
            redirect_d = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

    assign bp.mispredict  = mispredict_q;
    assign bp.redirect_pc = redirect_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side consumer of branch resolution results: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Lookup port: gives fetch a taken/target prediction for the current PC.
- Update port: takes resolved outcomes (func, taken, target) from the branch functional unit, trains the table and produces a registered mispredict/redirect to flush the pipeline.

Parameters:
- BTB_ENTRIES, 16, number of entries; power of two, minimum 2.
- IDX_W, $clog2(BTB_ENTRIES), index width (derived).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch lookup request.
- if_pc  in  `XLEN  fetch PC.
- pred_hit  out  1  valid entry whose tag matches if_pc (comb).
- pred_taken  out  1  predicted taken (comb).
- pred_target  out  `XLEN  predicted target; if_pc+4 when not taken (comb).
- upd_valid  in  1  resolved branch this cycle.
- upd_pc  in  `XLEN  PC of resolved branch.
- upd_func  in  ALU_FUNC  0x0e–0x13 conditional, 0x14 JAL, 0x15 JALR; other codes ignored.
- upd_taken  in  1  resolved direction (branch unit cond).
- upd_target  in  `XLEN  resolved target (branch unit target_pc).
- upd_pred_taken  in  1  prediction carried with the instruction.
- upd_pred_target  in  `XLEN  predicted target carried with the instruction.
- mispredict  out  1  registered flush request.
- redirect_pc  out  `XLEN  registered correct next PC.

Behaviour:
- Address fields:
  - index = pc[IDX_W+1:2].
  - tag = pc[`XLEN-1:IDX_W+2].
  - pc[1:0] ignored.
- Entry contents: valid, tag, target, ctr[1:0], uncond.
- Reset (async, reset_n=0): all valid=0, ctr=0, mispredict=0, redirect_pc=0. The table is fully cleared even if an update is pending.
- Lookup (combinational, zero latency):
  - hit = if_valid & valid & tag match.
  - pred_taken = hit & (uncond | ctr[1]).
  - pred_target = entry target if pred_taken, else if_pc+4.
  - if_valid=0 forces all three pred_* outputs to 0.
- Update (written at the clock edge when upd_valid=1 and func is a branch/jump):
  - Hit, conditional: ctr saturating +1 if taken (max 3), -1 if not (min 0); target overwritten when taken.
  - Hit, JAL/JALR: target overwritten, ctr=3, uncond=1.
  - Miss, taken: allocate or replace (valid=1, tag, target). Conditional gets ctr=2, uncond=0; JAL/JALR gets ctr=3, uncond=1.
  - Miss, not taken: no table change.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents (no bypass).
- Mispredict, registered one cycle after upd_valid:
  - mispredict = upd_valid & branch func & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - Cycles without a mispredict: mispredict=0 and redirect_pc holds its last value.
- Non-branch func with upd_valid=1: no table change, mispredict=0 next cycle.
- Arithmetic: +4 wraps modulo 2^`XLEN. Counters never wrap.

Decomposition:
- Shared package (sys_defs.svh):
  - BR_BEQ..BR_BGEU, BR_JAL, BR_JALR func constants (0x0e–0x15).
  - BTB_ENTRY_T struct {valid, tag, target, ctr, uncond}.
  - is_branch_func / is_uncond_func helper functions.
- Sub-module sat_counter2: 2-bit saturating next-state logic (inc/dec/set). The BTB array stays in the top.

Test Plan:
- Reset then lookup 0x1000 -> pred_hit=0, pred_taken=0, pred_target=0x1004; mispredict=0.
- Update BEQ pc=0x1000 taken target=0x1040, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x1040; lookup 0x1000 then hits, ctr=2, pred_target=0x1040.
- Three more taken updates then four not-taken at 0x1000 -> ctr 3,3,3 then 2,1,0,0; pred_taken=1 until ctr drops to 1, no counter wrap.
- JALR pc=0x2000 target=0x3000, then a second JALR with target 0x3100 -> uncond entry; lookup predicts 0x3100, independent of ctr.
- Alias: with 16 entries, a taken BNE at 0x1040 evicts the 0x1000 entry (same index, different tag) -> lookup 0x1000 misses; not-taken miss at 0x1080 leaves the table unchanged.
- Same-cycle lookup/update on 0x1000, plus reset_n pulsed low mid-update -> lookup shows old entry; after reset all lookups miss and mispredict=0.
